store_trace_unit: RTL and testbench
===================================

# store_trace_unit

Captures every data-memory store issued by the pipelined RV32I core's memory stage (mem_write, data_addr_m, write_data_m) into a small FIFO and drains it to a consumer through a valid/ready port. It also watches for the tohost convention to produce a registered test-done / pass / fail result. It sits directly downstream of the core's M-stage store port, alongside data memory, and gives benches and on-chip debug a lossless-or-flagged store trace.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2
- TOHOST_ADDR, 32'h0000_0064, byte address whose stores are treated as test-result writes

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state immediately
- mem_write  in  1  store strobe from the core M stage; one store per high cycle
- data_addr_m  in  32  store byte address
- write_data_m  in  32  store data
- rd_valid  out  1  FIFO head holds a valid entry
- rd_ready  in  1  consumer accepts the head this cycle
- rd_addr  out  32  head entry address; 0 when rd_valid=0
- rd_data  out  32  head entry data; 0 when rd_valid=0
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one store was dropped
- write_count  out  32  total mem_write cycles seen, including dropped ones
- done  out  1  test result has been written
- pass  out  1  result was pass (valid when done=1)
- fail_code  out  31  failing test number, data[31:1] (valid when done=1 and pass=0)

## Operation
- push = mem_write && (count < DEPTH || pop); pop = rd_valid && rd_ready.
- Push stores {data_addr_m, write_data_m} at the write pointer; pop advances the read pointer. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Full and popping in the same cycle: the push is accepted and count stays DEPTH.
- Empty with a push in the same cycle: the new entry is not visible on the read port until the next cycle. No bypass, so pop=0 in that cycle.
- mem_write while full and not popping: the store is dropped and overflow is set to 1. overflow clears only on rst.
- write_count increments on every mem_write=1 cycle and wraps at 2^32.
- Result FSM has three states: RUN (reset), PASS, FAIL. In RUN, a mem_write with data_addr_m == TOHOST_ADDR is evaluated as follows:
  - write_data_m == 1: go to PASS.
  - write_data_m odd and != 1: go to FAIL and latch fail_code = write_data_m[31:1].
  - write_data_m even: ignored, stay in RUN.
- PASS and FAIL are terminal until rst. Later tohost writes are ignored.
- done = (state != RUN); pass = (state == PASS). Both are registered state decodes.
- tohost stores are also pushed into the FIFO like any other store.
- rd_addr and rd_data are read combinationally from the head entry and gated to 0 when empty. Storage arrays are not reset.

## Timing
- Reset values: rd_valid 0, rd_addr 0, rd_data 0, count 0, overflow 0, write_count 0, done 0, pass 0, fail_code 0, FSM in RUN, pointers 0.
- A store at edge N sets rd_valid=1 and count+1 after edge N.
- Pop at edge N: the next entry or empty status is visible after edge N.
- A tohost write sampled at edge N makes done/pass/fail_code valid after edge N.
- rst asserted mid-operation clears the outputs asynchronously. Pending entries are discarded. Stores during rst are ignored.
- The first edge after rst deasserts is a normal capture edge.
- rd_ready has no combinational path to any output except through registered state.

## Test plan
- Reset then 3 stores (0x10=0xA, 0x14=0xB, 0x18=0xC), rd_ready=0 -> count=3, rd_valid=1, head 0x10/0xA; then rd_ready=1 -> entries drain in order over 3 cycles, then rd_valid=0 and rd_addr=rd_data=0.
- DEPTH+2 back-to-back stores with rd_ready=0 -> count=DEPTH, overflow=1, write_count=DEPTH+2, first DEPTH entries intact.
- FIFO full with simultaneous mem_write and rd_ready=1 -> count stays DEPTH, overflow stays 0, new entry appears last.
- Store 1 to 0x64 -> done=1 and pass=1 the next cycle; a later store of 7 to 0x64 leaves pass=1.
- Store 0x0000_0007 to 0x64 -> done=1, pass=0, fail_code=3. Store 0x4 to 0x64 beforehand -> ignored, done stays 0.
- rst pulse asserted between clock edges while count=5 and done=1 -> all outputs 0 immediately. Pushes resume after deassertion, with write pointer wrap verified over 2*DEPTH pushes/pops.

Source files
------------

// File: rtl/store_trace_unit.sv
// Store trace unit: captures every M-stage data-memory store into a FIFO drained over valid/ready,
// and decodes tohost writes into a sticky done/pass/fail_code result.
module store_trace_unit #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_0064
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_write,
    input  logic [31:0]              data_addr_m,
    input  logic [31:0]              write_data_m,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [31:0]              rd_addr,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [31:0]              write_count,
    output logic                     done,
    output logic                     pass,
    output logic [30:0]              fail_code
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    logic [31:0]      addr_mem_q [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [31:0]      write_count_q, write_count_d;
    state_t           state_q, state_d;
    logic [30:0]      fail_code_q, fail_code_d;

    logic             not_empty;
    logic             push;
    logic             pop;
    logic             tohost_hit;

    // FIFO control: a full FIFO still accepts a store when the head leaves in the same cycle.
    always_comb begin
        not_empty     = (count_q != '0);
        pop           = not_empty && rd_ready;
        push          = mem_write && ((count_q < DEPTH_CNT) || pop);

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        write_count_d = write_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (mem_write && !push) begin
            overflow_d = 1'b1;
        end
        if (mem_write) begin
            write_count_d = write_count_q + 32'd1;
        end
    end

    // Result FSM: only the first odd tohost value is decisive; even values are progress markers.
    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        tohost_hit  = mem_write && (data_addr_m == TOHOST_ADDR);

        case (state_q)
            ST_RUN: begin
                if (tohost_hit && write_data_m[0]) begin
                    if (write_data_m == 32'd1) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d     = ST_FAIL;
                        fail_code_d = write_data_m[31:1];
                    end
                end
            end
            ST_PASS: state_d = ST_PASS;
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            write_count_q <= '0;
            state_q       <= ST_RUN;
            fail_code_q   <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            write_count_q <= write_count_d;
            state_q       <= state_d;
            fail_code_q   <= fail_code_d;
        end
    end

    // Storage is data only; stale contents are never visible because count gates the read port.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            addr_mem_q[wr_ptr_q] <= data_addr_m;
            data_mem_q[wr_ptr_q] <= write_data_m;
        end
    end

    always_comb begin
        rd_valid    = not_empty;
        rd_addr     = not_empty ? addr_mem_q[rd_ptr_q] : 32'd0;
        rd_data     = not_empty ? data_mem_q[rd_ptr_q] : 32'd0;
        count       = count_q;
        overflow    = overflow_q;
        write_count = write_count_q;
        done        = (state_q != ST_RUN);
        pass        = (state_q == ST_PASS);
        fail_code   = fail_code_q;
    end

endmodule

// File: tb/tb_store_trace_unit.sv
// Scoreboard bench for store_trace_unit: a queue model predicts FIFO contents and result state.
module tb_store_trace_unit;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] TOHOST = 32'h0000_0064;

    logic        clk;
    logic        rst;
    logic        mem_write;
    logic [31:0] data_addr_m;
    logic [31:0] write_data_m;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [$clog2(DEPTH):0] count;
    logic        overflow;
    logic [31:0] write_count;
    logic        done;
    logic        pass;
    logic [30:0] fail_code;

    store_trace_unit #(.DEPTH(DEPTH), .TOHOST_ADDR(TOHOST)) dut (
        .clk(clk), .rst(rst), .mem_write(mem_write), .data_addr_m(data_addr_m),
        .write_data_m(write_data_m), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .overflow(overflow),
        .write_count(write_count), .done(done), .pass(pass), .fail_code(fail_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        sb_q[$];
    int          n_checks;
    int          n_errors;
    logic        m_ovf;
    logic [31:0] m_wc;
    int          m_state;   // 0 run, 1 pass, 2 fail
    logic [30:0] m_fc;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_ovf   = 1'b0;
        m_wc    = 32'd0;
        m_state = 0;
        m_fc    = '0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".count"},     64'(count), 64'(sb_q.size()));
        check_eq({tag, ".rd_valid"},  64'(rd_valid), 64'(sb_q.size() != 0));
        if (sb_q.size() == 0) begin
            check_eq({tag, ".rd_addr0"}, 64'(rd_addr), 64'd0);
            check_eq({tag, ".rd_data0"}, 64'(rd_data), 64'd0);
        end
        check_eq({tag, ".overflow"},  64'(overflow), 64'(m_ovf));
        check_eq({tag, ".wcount"},    64'(write_count), 64'(m_wc));
        check_eq({tag, ".done"},      64'(done), 64'(m_state != 0));
        check_eq({tag, ".pass"},      64'(pass), 64'(m_state == 1));
        check_eq({tag, ".fail_code"}, 64'(fail_code), 64'(m_fc));
    endtask

    // One clock cycle; called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input string tag, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy);
        int   sz;
        logic pop_m;
        logic push_m;
        ent_t head;
        mem_write    = we;
        data_addr_m  = a;
        write_data_m = d;
        rd_ready     = rdy;
        #1;
        sz     = sb_q.size();
        pop_m  = (sz != 0) && rdy;
        push_m = we && ((sz < int'(DEPTH)) || pop_m);
        if (pop_m) begin
            head = sb_q.pop_front();
            check_eq({tag, ".pop_addr"}, 64'(rd_addr), 64'(head.a));
            check_eq({tag, ".pop_data"}, 64'(rd_data), 64'(head.d));
        end
        if (push_m) sb_q.push_back({a, d});
        if (we && !push_m) m_ovf = 1'b1;
        if (we) m_wc = m_wc + 32'd1;
        if (m_state == 0 && we && a == TOHOST && d[0]) begin
            if (d == 32'd1) m_state = 1;
            else begin
                m_state = 2;
                m_fc    = d[31:1];
            end
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    // Asynchronous reset pulse raised between edges; a store presented during reset must be ignored.
    task automatic mid_reset(input string tag);
        mem_write = 1'b0;
        rd_ready  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_state({tag, ".async"});
        mem_write    = 1'b1;
        data_addr_m  = TOHOST;
        write_data_m = 32'd1;
        @(posedge clk);
        #1;
        check_state({tag, ".held"});
        mem_write = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        check_state({tag, ".idle"});
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        mem_write    = 1'b0;
        data_addr_m  = '0;
        write_data_m = '0;
        rd_ready     = 1'b0;
        model_clear();
        #3;
        check_state("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Three stores held, then drained in order.
        cycle("st0", 1'b1, 32'h10, 32'hA, 1'b0);
        cycle("st1", 1'b1, 32'h14, 32'hB, 1'b0);
        cycle("st2", 1'b1, 32'h18, 32'hC, 1'b0);
        check_eq("three.count", 64'(count), 64'd3);
        check_eq("three.head_addr", 64'(rd_addr), 64'h10);
        check_eq("three.head_data", 64'(rd_data), 64'hA);
        for (int i = 0; i < 4; i++) cycle("drain3", 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("three.empty", 64'(rd_valid), 64'd0);

        // Overflow: DEPTH+2 stores without draining.
        mid_reset("rst_a");
        for (int i = 0; i < int'(DEPTH) + 2; i++)
            cycle("ovf_fill", 1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
        check_eq("ovf.count", 64'(count), 64'(DEPTH));
        check_eq("ovf.flag", 64'(overflow), 64'd1);
        check_eq("ovf.wcount", 64'(write_count), 64'(DEPTH + 2));
        for (int i = 0; i < int'(DEPTH) + 1; i++) cycle("ovf_drain", 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("ovf.sticky", 64'(overflow), 64'd1);

        // Full with simultaneous push and pop.
        mid_reset("rst_b");
        for (int i = 0; i < int'(DEPTH); i++)
            cycle("full_fill", 1'b1, 32'h200 + 32'(4 * i), 32'h2000 + 32'(i), 1'b0);
        cycle("full_pp", 1'b1, 32'h2FC, 32'hBEEF, 1'b1);
        check_eq("fullpp.count", 64'(count), 64'(DEPTH));
        check_eq("fullpp.ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < int'(DEPTH) + 1; i++) cycle("full_drain", 1'b0, 32'h0, 32'h0, 1'b1);

        // tohost pass, then a later odd write leaves the result untouched.
        mid_reset("rst_c");
        cycle("th_pass", 1'b1, TOHOST, 32'd1, 1'b0);
        check_eq("pass.done", 64'(done), 64'd1);
        check_eq("pass.pass", 64'(pass), 64'd1);
        cycle("th_late", 1'b1, TOHOST, 32'd7, 1'b0);
        check_eq("pass.sticky", 64'(pass), 64'd1);

        // Even tohost ignored, then fail code 3.
        mid_reset("rst_d");
        cycle("th_even", 1'b1, TOHOST, 32'd4, 1'b0);
        check_eq("even.done", 64'(done), 64'd0);
        cycle("th_fail", 1'b1, TOHOST, 32'd7, 1'b0);
        check_eq("fail.done", 64'(done), 64'd1);
        check_eq("fail.pass", 64'(pass), 64'd0);
        check_eq("fail.code", 64'(fail_code), 64'd3);
        for (int i = 0; i < 3; i++) cycle("fill5", 1'b1, 32'h300 + 32'(4 * i), 32'(i), 1'b0);
        check_eq("pre_rst.count", 64'(count), 64'd5);

        // Reset mid-operation, then pointer wrap with continuous push/pop.
        mid_reset("rst_e");
        for (int i = 0; i < 2 * int'(DEPTH) + 3; i++)
            cycle("wrap", 1'b1, 32'h400 + 32'(4 * i), 32'h4000 + 32'(i), (i % 3) != 0);
        for (int i = 0; i < int'(DEPTH) + 1; i++) cycle("wrap_drain", 1'b0, 32'h0, 32'h0, 1'b1);

        // Mixed random traffic.
        for (int i = 0; i < 60; i++)
            cycle("rand", 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                  ($urandom_range(0, 3) == 0));
        for (int i = 0; i < int'(DEPTH) + 1; i++) cycle("rand_drain", 1'b0, 32'h0, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
